// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and segment decoder for the 7-segment display driver.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Active-low {dp,g..a}; dp always off.
    function automatic logic [7:0] hex_to_7seg(input logic [3:0] h);
        logic [6:0] on;
        case (h)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
        return {1'b1, ~on};
    endfunction

endpackage

// File: rtl/seg_display_seq_if.sv
// Request/result bundle between the datapath and the display driver.
interface seg_display_seq_if #(
    parameter int unsigned N_DIGITS = 6,
    parameter int unsigned BIN_W    = 20
);
    logic [BIN_W-1:0]      value_i;
    logic                  signed_i;
    logic                  start_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  overflow_o;
    logic [8*N_DIGITS-1:0] hex_o;

    modport master (output value_i, signed_i, start_i,
                    input  busy_o, done_o, overflow_o, hex_o);
    modport slave  (input  value_i, signed_i, start_i,
                    output busy_o, done_o, overflow_o, hex_o);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one magnitude bit shifted into the BCD accumulator per enabled edge.
module bin2bcd_seq #(
    parameter int unsigned BIN_W = 20,
    parameter int unsigned BCD_D = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIN_W-1:0]     mag,
    input  logic                 shift_en,
    output logic [4*BCD_D-1:0]   bcd
);

    logic [BIN_W-1:0]   sh;
    logic [4*BCD_D-1:0] adj_c;

    // Add-3 correction on every digit that would exceed 9 after doubling.
    always_comb begin
        adj_c = bcd;
        for (int unsigned i = 0; i < BCD_D; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            bcd <= '0;
        end else if (load) begin
            sh  <= mag;
            bcd <= '0;
        end else if (shift_en) begin
            bcd <= {adj_c[4*BCD_D-2:0], sh[BIN_W-1]};
            sh  <= {sh[BIN_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seg_display_seq.sv
// Sequential binary-to-7-segment driver: sign handling, BCD conversion, blanking and overflow dashes.
module seg_display_seq
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 6,
    parameter int unsigned BIN_W    = 20,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_seq_if.slave   bus
);

    localparam int unsigned BCD_D = (BIN_W + 2) / 3;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned PAD_D = (N_DIGITS > BCD_D) ? N_DIGITS : BCD_D;
    localparam int unsigned PAD_W = 4 * PAD_D;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;
    logic                  load_c, shift_c;
    logic [BIN_W-1:0]      mag_c;
    logic [4*BCD_D-1:0]    bcd;
    logic [PAD_W-1:0]      bcd_pad;
    logic                  ovf_c;
    logic [8*N_DIGITS-1:0] hex_c;
    int unsigned           top_c, nd_mag_c, nd_c, sign_pos_c;
    logic                  busy_q, done_q, ovf_q;
    logic [8*N_DIGITS-1:0] hex_q;

    // Two's-complement magnitude; the most negative value maps exactly onto its unsigned pattern.
    assign mag_c = (bus.signed_i && bus.value_i[BIN_W-1]) ? (~bus.value_i + BIN_W'(1))
                                                          : bus.value_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    load_c    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                shift_c = 1'b1;
                if (cnt == CNT_W'(BIN_W - 1)) state_nxt = LATCH;
            end
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    bin2bcd_seq #(.BIN_W(BIN_W), .BCD_D(BCD_D)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .mag      (mag_c),
        .shift_en (shift_c),
        .bcd      (bcd)
    );

    assign bcd_pad = PAD_W'(bcd);

    // Digit count, overflow and per-digit segment selection from the finished BCD value.
    always_comb begin
        top_c = 0;
        for (int unsigned i = 0; i < BCD_D; i++) begin
            if (bcd[4*i +: 4] != 4'd0) top_c = i;
        end
        nd_mag_c   = top_c + 1;
        nd_c       = nd_mag_c + (neg ? 1 : 0);
        ovf_c      = (nd_c > N_DIGITS);
        sign_pos_c = (BLANK_LZ != 0) ? nd_mag_c : N_DIGITS - 1;
        hex_c      = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (ovf_c)                            hex_c[8*i +: 8] = SEG_DASH;
            else if (neg && i == sign_pos_c)      hex_c[8*i +: 8] = SEG_DASH;
            else if (i < nd_mag_c || BLANK_LZ == 0) hex_c[8*i +: 8] = hex_to_7seg(bcd_pad[4*i +: 4]);
            else                                  hex_c[8*i +: 8] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            hex_q  <= {N_DIGITS{SEG_BLANK}};
        end else begin
            busy_q <= (state_nxt == CONV);
            done_q <= (state == LATCH);
            if (load_c) begin
                cnt <= '0;
                neg <= bus.signed_i & bus.value_i[BIN_W-1];
            end else if (shift_c) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == LATCH) begin
                hex_q <= hex_c;
                ovf_q <= ovf_c;
            end
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.overflow_o = ovf_q;
    assign bus.hex_o      = hex_q;

endmodule

// File: tb/tb_seg_display_seq.sv
// Directed bench: two drivers (leading-zero blanking on/off) fed the same requests.
module tb_seg_display_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] seg_t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    seg_display_seq_if #(.N_DIGITS(6), .BIN_W(20)) bus_a ();
    seg_display_seq_if #(.N_DIGITS(6), .BIN_W(20)) bus_b ();

    assign bus_b.value_i  = bus_a.value_i;
    assign bus_b.signed_i = bus_a.signed_i;
    assign bus_b.start_i  = bus_a.start_i;

    seg_display_seq #(.N_DIGITS(6), .BIN_W(20), .BLANK_LZ(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seg_display_seq #(.N_DIGITS(6), .BIN_W(20), .BLANK_LZ(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Leftmost character is digit 5; ' ' blank, '-' dash, '0'..'9' numerals.
    function automatic logic [47:0] exp6(input string s);
        logic [47:0] r;
        byte c;
        r = '0;
        for (int d = 0; d < 6; d++) begin
            c = s[5-d];
            if (c == " ")      r[8*d +: 8] = 8'hFF;
            else if (c == "-") r[8*d +: 8] = 8'hBF;
            else               r[8*d +: 8] = seg_t[int'(c) - 48];
        end
        return r;
    endfunction

    task automatic run(input logic [19:0] v, input logic s, output int lat, output int nbusy);
        @(negedge clk);
        bus_a.value_i  = v;
        bus_a.signed_i = s;
        bus_a.start_i  = 1'b1;
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        nbusy = bus_a.busy_o ? 1 : 0;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus_a.done_o) begin
                lat = k;
                break;
            end
            if (bus_a.busy_o) nbusy++;
        end
    endtask

    task automatic conv(input string tag, input logic [19:0] v, input logic s,
                        input string ea, input logic ovf);
        int lat, nb;
        run(v, s, lat, nb);
        check({tag, "_lat"}, 64'(lat), 64'd21);
        check({tag, "_hex"}, 64'(bus_a.hex_o), 64'(exp6(ea)));
        check({tag, "_ovf"}, 64'(bus_a.overflow_o), 64'(ovf));
    endtask

    initial begin
        int lat, nb;
        bus_a.value_i  = '0;
        bus_a.signed_i = 1'b0;
        bus_a.start_i  = 1'b0;
        @(posedge clk); #1;
        check("rst_hex_a", 64'(bus_a.hex_o), 64'hFFFF_FFFF_FFFF);
        check("rst_hex_b", 64'(bus_b.hex_o), 64'hFFFF_FFFF_FFFF);
        check("rst_busy",  64'(bus_a.busy_o), 64'd0);
        check("rst_done",  64'(bus_a.done_o), 64'd0);
        check("rst_ovf",   64'(bus_a.overflow_o), 64'd0);
        @(negedge clk); rst = 1'b0;

        run(20'd1234, 1'b0, lat, nb);
        check("u1234_lat",  64'(lat), 64'd21);
        check("u1234_busy", 64'(nb), 64'd20);
        check("u1234_hex",  64'(bus_a.hex_o), 64'(exp6("  1234")));
        check("u1234_hexb", 64'(bus_b.hex_o), 64'(exp6("001234")));
        check("u1234_ovf",  64'(bus_a.overflow_o), 64'd0);
        @(posedge clk); #1;
        check("done_pulse", 64'(bus_a.done_o), 64'd0);

        conv("s_m45", 20'hFFFD3, 1'b1, "   -45", 1'b0);
        check("s_m45_hexb", 64'(bus_b.hex_o), 64'(exp6("-00045")));
        conv("s_m99999", 20'(-99999), 1'b1, "-99999", 1'b0);
        conv("s_m100000", 20'(-100000), 1'b1, "------", 1'b1);
        conv("u999999", 20'd999999, 1'b0, "999999", 1'b0);
        conv("u1000000", 20'd1000000, 1'b0, "------", 1'b1);
        conv("u7", 20'd7, 1'b0, "     7", 1'b0);
        conv("u0", 20'd0, 1'b0, "     0", 1'b0);
        check("u0_hexb", 64'(bus_b.hex_o), 64'(exp6("000000")));
        conv("s_min", 20'h80000, 1'b1, "------", 1'b1);
        check("s_min_hexb", 64'(bus_b.hex_o), 64'(exp6("------")));
        check("s_min_ovfb", 64'(bus_b.overflow_o), 64'd1);
        // Same bit pattern read as unsigned is 524288: fits, no sign.
        conv("u524288", 20'h80000, 1'b0, "524288", 1'b0);

        // start held high; value changes mid-conversion; second request follows immediately.
        @(negedge clk);
        bus_a.value_i  = 20'd111;
        bus_a.signed_i = 1'b0;
        bus_a.start_i  = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 5) bus_a.value_i = 20'd222;
            if (bus_a.done_o) begin
                lat = k;
                break;
            end
        end
        check("b2b_lat1", 64'(lat), 64'd21);
        check("b2b_hex1", 64'(bus_a.hex_o), 64'(exp6("   111")));
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        check("b2b_restart", 64'(bus_a.busy_o), 64'd1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus_a.done_o) begin
                lat = k;
                break;
            end
        end
        check("b2b_lat2", 64'(lat), 64'd21);
        check("b2b_hex2", 64'(bus_a.hex_o), 64'(exp6("   222")));

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus_a.value_i = 20'd123;
        bus_a.start_i = 1'b1;
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_hex",  64'(bus_a.hex_o), 64'hFFFF_FFFF_FFFF);
        check("midrst_busy", 64'(bus_a.busy_o), 64'd0);
        nb = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_a.done_o) nb++;
        end
        @(negedge clk); rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus_a.done_o) nb++;
        end
        check("midrst_nodone", 64'(nb), 64'd0);
        conv("u42", 20'd42, 1'b0, "    42", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
